fm_write_queue: RTL and testbench
=================================

FM_WRITE_QUEUE -- requirements
Module: fm_write_queue

Interface
REQ-001 Parameter COUNT, default 3, number of attached FM chip instances (legal 1..4).
REQ-002 Parameter DEPTH, default 8, per-instance write FIFO entries (power of two, 2..32).
REQ-003 Parameter ADDR_TICKS, default 12, ce ticks a chip stays busy after an address write (a0=0).
REQ-004 Parameter DATA_TICKS, default 68, ce ticks a chip stays busy after a data write (a0=1).
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 ce  in  1  chip clock enable (1.79 MHz tick), one clk wide.
REQ-008 cs  in  COUNT  per-instance select from I/O or device decode; at most one bit set.
REQ-009 wr  in  1  CPU write strobe, qualified by cs, one clk wide.
REQ-010 rd  in  1  CPU read, qualified by cs, level.
REQ-011 a0  in  1  register/address select.
REQ-012 din  in  8  CPU write data.
REQ-013 dout  out  8  CPU read data.
REQ-014 chip_cs_n  out  COUNT  per-chip select, active-low.
REQ-015 chip_wr_n  out  1  shared chip write strobe, active-low.
REQ-016 chip_a0  out  1  shared chip a0.
REQ-017 chip_din  out  8  shared chip write data.
REQ-018 chip_dout  in  COUNT*8  per-chip read data, instance i at bits [8i+7:8i].
REQ-019 chip_irq_n  in  COUNT  per-chip interrupt, active-low.
REQ-020 irq  out  1  combined interrupt, active-high.
REQ-021 overflow  out  COUNT  per-instance sticky dropped-write flag.

Function
REQ-022 Each instance SHALL own a FIFO of {a0,din} (9 bits), DEPTH entries, occupancy counter $clog2(DEPTH)+1 bits, pointers wrap modulo DEPTH.
REQ-023 wr with cs[i]=1 SHALL push into FIFO i at that clk edge if not full; full is evaluated before any same-cycle pop.
REQ-024 Push while full SHALL drop the write and set overflow[i]; overflow[i] clears only on a CPU read of instance i with a0=0, or on reset.
REQ-025 Each instance SHALL hold a busy timer loaded with ADDR_TICKS or DATA_TICKS on issue, decremented on ce, saturating at 0.
REQ-026 Instance i is eligible when FIFO non-empty, timer 0, and no issue already in flight.
REQ-027 Issue FSM states IDLE, ISSUE: IDLE->ISSUE when any instance eligible and rd inactive; ISSUE->IDLE after exactly one clk.
REQ-028 Arbitration SHALL be round-robin starting from the instance after the last one issued; after reset start at instance 0.
REQ-029 In ISSUE: selected chip_cs_n bit=0, chip_wr_n=0, chip_a0/chip_din=FIFO head, for one clk; pop and timer load occur on that cycle's closing edge.
REQ-030 Latency: wr on cycle n to an empty, idle instance SHALL produce chip_wr_n=0 on cycle n+2.
REQ-031 Outside ISSUE: chip_wr_n=1; chip_a0=a0, chip_din=din pass through.
REQ-032 CPU read (rd and cs[i]) SHALL drive chip_cs_n[i]=0 combinationally, bypassing the queue; rd active blocks IDLE->ISSUE.
REQ-033 dout SHALL be chip_dout[i] of the selected instance, with bit 7 forced 1 when a0=0 and FIFO i non-empty or timer i non-zero; 8'hFF when no cs bit set or rd inactive.
REQ-034 irq SHALL be registered: irq <= any chip_irq_n[i]==0.
REQ-035 Simultaneous push and pop on one FIFO SHALL leave occupancy unchanged and keep data order.

Reset
REQ-036 reset_n=0 SHALL asynchronously clear FIFOs, pointers, timers, overflow, round-robin pointer, FSM to IDLE, irq=0, chip_cs_n all 1, chip_wr_n=1.
REQ-037 Reset mid-ISSUE SHALL deassert chip_wr_n and chip_cs_n immediately; queued writes are discarded.

Verification
REQ-038 wr a0=0 din=0x20 to instance 0 on cycle n -> chip_cs_n=110, chip_wr_n=0, chip_a0=0, chip_din=0x20 on cycle n+2 only.
REQ-039 Pushes (0,0x28),(1,0x4A) back-to-back to instance 1 -> second issue not before 12 ce ticks after first; next issue after that not before 68 ticks.
REQ-040 DEPTH+1 writes to instance 2 while busy -> last dropped, overflow=100; read a0=0 -> dout bit7=1, overflow cleared to 000.
REQ-041 Instances 0,1,2 each with one pending write, all timers 0 -> issue order 0,1,2 on cycles k, k+2, k+4.
REQ-042 chip_irq_n=101 -> irq=1 next clk; chip_irq_n=111 -> irq=0 next clk.
REQ-043 Assert reset_n=0 during ISSUE with 3 queued entries -> chip_wr_n=1 immediately; after release no chip write occurs.

Source files
------------

// File: rtl/fm_write_queue.sv
// fm_write_queue: per-chip write queues in front of up to four FM sound chips.
// CPU writes are buffered per instance and replayed to the chips one at a time,
// each chip being held off for a busy window after every write it receives.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   ce                    chip tick enable (one clk wide)
//   cs[COUNT]             instance select (at most one bit set)
//   wr, rd, a0, din       CPU write strobe, read level, register select, write data
//   dout                  CPU read data
//   chip_cs_n[COUNT]      per-chip select, active-low
//   chip_wr_n, chip_a0,   shared chip write bus
//   chip_din
//   chip_dout             per-chip read data, instance i at [8i+7:8i]
//   chip_irq_n[COUNT]     per-chip interrupt, active-low
//   irq                   registered combined interrupt
//   overflow[COUNT]       sticky dropped-write flags
module fm_write_queue #(
    parameter int unsigned COUNT      = 3,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_TICKS = 12,
    parameter int unsigned DATA_TICKS = 68
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic [COUNT-1:0]   cs,
    input  logic               wr,
    input  logic               rd,
    input  logic               a0,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic [COUNT-1:0]   chip_cs_n,
    output logic               chip_wr_n,
    output logic               chip_a0,
    output logic [7:0]         chip_din,
    input  logic [COUNT*8-1:0] chip_dout,
    input  logic [COUNT-1:0]   chip_irq_n,
    output logic               irq,
    output logic [COUNT-1:0]   overflow
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned TMAX = (ADDR_TICKS > DATA_TICKS) ? ADDR_TICKS : DATA_TICKS;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned IW   = (COUNT > 1) ? $clog2(COUNT) : 1;

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   sel_q, sel_d;     // instance being issued / last issued
    logic            irq_q;

    logic [COUNT-1:0] elig;
    logic [COUNT-1:0] busy;
    logic [8:0]       head [COUNT];

    // ------------------------------------------------------------------
    // Per-instance FIFO, busy timer and overflow flag
    // ------------------------------------------------------------------
    for (genvar g = 0; g < COUNT; g++) begin : g_inst
        logic [8:0]    mem_q [DEPTH];
        logic [PW-1:0] wptr_q, rptr_q;
        logic [PW:0]   cnt_q;
        logic [TW-1:0] tmr_q;
        logic          ovf_q;
        logic          full, push, pop;

        // Full is judged on the registered count, before any same-cycle pop.
        assign full = (cnt_q == (PW+1)'(DEPTH));
        assign push = wr & cs[g] & ~full;
        assign pop  = (state_q == StIssue) && (sel_q == IW'(g));

        assign head[g]     = mem_q[rptr_q];
        assign busy[g]     = (cnt_q != '0) || (tmr_q != '0);
        assign elig[g]     = (cnt_q != '0) && (tmr_q == '0) && (state_q == StIdle);
        assign overflow[g] = ovf_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned d = 0; d < DEPTH; d++) begin
                    mem_q[d] <= '0;
                end
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                tmr_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (push) begin
                    mem_q[wptr_q] <= {a0, din};
                    wptr_q        <= wptr_q + 1'b1;
                end
                if (pop) begin
                    rptr_q <= rptr_q + 1'b1;
                end
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
                // A load on the issue edge takes precedence over a coincident tick.
                if (pop) begin
                    tmr_q <= head[g][8] ? TW'(DATA_TICKS) : TW'(ADDR_TICKS);
                end else if (ce && (tmr_q != '0)) begin
                    tmr_q <= tmr_q - 1'b1;
                end
                // A drop in the same cycle as a clearing read keeps the flag set.
                if (wr && cs[g] && full) begin
                    ovf_q <= 1'b1;
                end else if (rd && cs[g] && !a0) begin
                    ovf_q <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM with round-robin arbitration
    // ------------------------------------------------------------------
    int            cand;
    logic [IW-1:0] cand_idx;
    logic          found;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        unique case (state_q)
            StIdle: begin
                if (!rd) begin
                    // Search starts one past the last issued instance.
                    for (int k = 1; k <= int'(COUNT); k++) begin
                        cand     = (int'(sel_q) + k) % int'(COUNT);
                        cand_idx = IW'(cand);
                        if (!found && elig[cand_idx]) begin
                            found = 1'b1;
                            sel_d = cand_idx;
                        end
                    end
                    if (found) begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            sel_q   <= IW'(COUNT - 1);   // first search lands on instance 0
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            irq_q   <= |(~chip_irq_n);
        end
    end

    // ------------------------------------------------------------------
    // Chip bus and CPU read path
    // ------------------------------------------------------------------
    logic [8:0] issue_word;

    always_comb begin
        issue_word = '0;
        chip_cs_n  = '1;
        for (int i = 0; i < int'(COUNT); i++) begin
            if ((state_q == StIssue) && (sel_q == IW'(i))) begin
                issue_word   = head[i];
                chip_cs_n[i] = 1'b0;
            end
            if (rd && cs[i]) begin
                chip_cs_n[i] = 1'b0;
            end
        end
    end

    assign chip_wr_n = (state_q != StIssue);
    assign chip_a0   = (state_q == StIssue) ? issue_word[8]   : a0;
    assign chip_din  = (state_q == StIssue) ? issue_word[7:0] : din;
    assign irq       = irq_q;

    always_comb begin
        dout = 8'hFF;
        if (rd) begin
            for (int i = 0; i < int'(COUNT); i++) begin
                if (cs[i]) begin
                    dout = chip_dout[8*i +: 8];
                    // Status read reports the chip busy while our queue still owns it.
                    if (!a0 && busy[i]) begin
                        dout[7] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fm_write_queue.sv
// Directed bench for fm_write_queue with default parameters (3 chips, depth 8,
// 12/68 tick busy windows).
module tb_fm_write_queue;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic [2:0]  cs;
    logic        wr;
    logic        rd;
    logic        a0;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [2:0]  chip_cs_n;
    logic        chip_wr_n;
    logic        chip_a0;
    logic [7:0]  chip_din;
    logic [23:0] chip_dout;
    logic [2:0]  chip_irq_n;
    logic        irq;
    logic [2:0]  overflow;

    int passes = 0;
    int total  = 0;
    int hits;

    fm_write_queue dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .cs         (cs),
        .wr         (wr),
        .rd         (rd),
        .a0         (a0),
        .din        (din),
        .dout       (dout),
        .chip_cs_n  (chip_cs_n),
        .chip_wr_n  (chip_wr_n),
        .chip_a0    (chip_a0),
        .chip_din   (chip_din),
        .chip_dout  (chip_dout),
        .chip_irq_n (chip_irq_n),
        .irq        (irq),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // n ce pulses, counting every sampled cycle with a chip write in progress.
    task automatic ticks(input int n, output int nwr);
        nwr = 0;
        for (int t = 0; t < n; t++) begin
            ce = 1'b1;
            step();
            if (chip_wr_n === 1'b0) nwr++;
            ce = 1'b0;
            step();
            if (chip_wr_n === 1'b0) nwr++;
        end
    endtask

    task automatic cpu_wr(input logic [2:0] sel, input logic ad, input logic [7:0] d);
        cs  = sel;
        wr  = 1'b1;
        a0  = ad;
        din = d;
    endtask

    initial begin
        reset_n    = 1'b0;
        ce         = 1'b0;
        cs         = '0;
        wr         = 1'b0;
        rd         = 1'b0;
        a0         = 1'b0;
        din        = '0;
        chip_dout  = {8'h11, 8'h03, 8'h05};
        chip_irq_n = 3'b111;

        // Reset state
        #12;
        chk("rst_cs_n", chip_cs_n, 3'b111);
        chk("rst_wr_n", chip_wr_n, 1'b1);
        chk("rst_irq", irq, 1'b0);
        chk("rst_ovf", overflow, 3'b000);
        chk("rst_dout", dout, 8'hFF);
        #11 reset_n = 1'b1;
        step();

        // Round-robin from reset: reads hold off issue while three writes queue up
        rd = 1'b1;
        cpu_wr(3'b001, 1'b0, 8'h01); step();
        cpu_wr(3'b010, 1'b0, 8'h02); step();
        cpu_wr(3'b100, 1'b0, 8'h03); step();
        wr = 1'b0; rd = 1'b0; cs = '0;
        chk("rr_blocked", chip_wr_n, 1'b1);
        step();
        chk("rr_k_cs", chip_cs_n, 3'b110);
        chk("rr_k_din", chip_din, 8'h01);
        step();
        chk("rr_k1_wr", chip_wr_n, 1'b1);
        step();
        chk("rr_k2_cs", chip_cs_n, 3'b101);
        chk("rr_k2_din", chip_din, 8'h02);
        step();
        step();
        chk("rr_k4_cs", chip_cs_n, 3'b011);
        chk("rr_k4_din", chip_din, 8'h03);
        step();
        ticks(12, hits);
        chk("rr_quiet", hits, 0);

        // Two-cycle latency on an idle instance
        cpu_wr(3'b001, 1'b0, 8'h20);
        step();
        wr = 1'b0; cs = '0;
        chk("lat_n1_wr", chip_wr_n, 1'b1);
        step();
        chk("lat_n2_wr", chip_wr_n, 1'b0);
        chk("lat_n2_cs", chip_cs_n, 3'b110);
        chk("lat_n2_a0", chip_a0, 1'b0);
        chk("lat_n2_din", chip_din, 8'h20);
        step();
        din = 8'h55; a0 = 1'b1;
        #1;
        chk("lat_n3_wr", chip_wr_n, 1'b1);
        chk("lat_n3_cs", chip_cs_n, 3'b111);
        chk("pass_din", chip_din, 8'h55);
        chk("pass_a0", chip_a0, 1'b1);

        // Address then data to instance 1: 12-tick then 68-tick busy windows
        cpu_wr(3'b010, 1'b0, 8'h28); step();
        cpu_wr(3'b010, 1'b1, 8'h4A); step();
        wr = 1'b0; cs = '0;
        chk("bz_first_din", chip_din, 8'h28);
        chk("bz_first_wr", chip_wr_n, 1'b0);
        step();
        ticks(11, hits);
        chk("bz_addr_hold", hits, 0);
        ce = 1'b1; step(); ce = 1'b0;
        chk("bz_addr_edge", chip_wr_n, 1'b1);
        step();
        chk("bz_second_wr", chip_wr_n, 1'b0);
        chk("bz_second_cs", chip_cs_n, 3'b101);
        chk("bz_second_a0", chip_a0, 1'b1);
        chk("bz_second_din", chip_din, 8'h4A);
        // Push lands on the same edge as the pop
        cpu_wr(3'b010, 1'b0, 8'h10);
        step();
        wr = 1'b0; rd = 1'b1; a0 = 1'b0;
        #1;
        chk("rd_busy_dout", dout, 8'h83);
        chk("rd_cs_n", chip_cs_n, 3'b101);
        a0 = 1'b1;
        #1;
        chk("rd_data_dout", dout, 8'h03);
        rd = 1'b0; cs = '0;
        #1;
        chk("rd_idle_dout", dout, 8'hFF);
        ticks(67, hits);
        chk("bz_data_hold", hits, 0);
        ce = 1'b1; step(); ce = 1'b0;
        chk("bz_data_edge", chip_wr_n, 1'b1);
        step();
        chk("bz_third_wr", chip_wr_n, 1'b0);
        chk("bz_third_din", chip_din, 8'h10);
        chk("bz_third_a0", chip_a0, 1'b0);
        step();

        // Overflow on instance 2
        for (int i = 0; i < 10; i++) begin
            cpu_wr(3'b100, 1'b1, (i == 0) ? 8'h99 : 8'hA0 + 8'(i));
            step();
            if (i == 1) begin
                chk("ov_issue_wr", chip_wr_n, 1'b0);
                chk("ov_issue_cs", chip_cs_n, 3'b011);
                chk("ov_issue_din", chip_din, 8'h99);
            end
            if (i == 8) chk("ov_full_flag", overflow, 3'b000);
            if (i == 9) chk("ov_drop_flag", overflow, 3'b100);
        end
        wr = 1'b0; rd = 1'b1; a0 = 1'b0; cs = 3'b100;
        #1;
        chk("ov_rd_dout", dout, 8'h91);
        step();
        chk("ov_cleared", overflow, 3'b000);
        cs = 3'b001;
        #1;
        chk("rd_idle_inst_dout", dout, 8'h05);
        rd = 1'b0; cs = '0;

        // Interrupt register
        chip_irq_n = 3'b101;
        #1;
        chk("irq_not_yet", irq, 1'b0);
        step();
        chk("irq_set", irq, 1'b1);
        chip_irq_n = 3'b111;
        step();
        chk("irq_clr", irq, 1'b0);

        // Reset while a write is on the chip bus
        rd = 1'b1;
        cpu_wr(3'b001, 1'b1, 8'hC1); step();
        cpu_wr(3'b001, 1'b1, 8'hC2); step();
        cpu_wr(3'b001, 1'b1, 8'hC3); step();
        wr = 1'b0; rd = 1'b0; cs = '0;
        step();
        chk("mid_issue_wr", chip_wr_n, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_wr", chip_wr_n, 1'b1);
        chk("mid_rst_cs", chip_cs_n, 3'b111);
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (chip_wr_n === 1'b0) hits++;
        end
        chk("post_rst_quiet", hits, 0);
        chk("post_rst_ovf", overflow, 3'b000);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
